sumsq_accum: RTL and testbench

Streaming sum-of-squares accumulator. It is the producer that drives the square-root pipeline's `data_in`/`data_valid` input: it squares signed samples, accumulates them per frame with saturation, and emits one 32-bit sum per frame as a single-cycle valid pulse. The sqrt pipeline has no backpressure, so this block never stalls its output and accepts one sample per clock with no bubbles.

---
 rtl/sumsq_accum.sv | 147 ++++++++++++++
 tb/tb_sumsq_accum.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sumsq_accum.sv
// Streaming sum-of-squares accumulator feeding the square-root pipeline.
// Three registered stages (input, square, accumulate) plus a registered result
// stage, giving a fixed three-clock latency from the closing sample to data_valid.
// One sample per clock with no stalls; frames may be back to back.
module sumsq_accum #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned MAX_LEN  = 1024,
  parameter int unsigned CNT_W    = 11
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       sample_last,
  output logic [31:0]                data_out,
  output logic                       data_valid,
  output logic                       sat_flag,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           sample_count
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_LEN);

  // Stage 1 registers
  logic signed [SAMPLE_W-1:0] s1_sample_q;
  logic                       s1_valid_q, s1_last_q;

  // Stage 2 registers
  logic [31:0] s2_sq_q, s2_sq_d;
  logic        s2_valid_q, s2_last_q;
  logic signed [2*SAMPLE_W-1:0] sq_full;

  // Stage 3 (accumulator) state
  state_e           state_q;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             err_q;
  logic             close_q;

  // Result registers
  logic [31:0]      data_q;
  logic             valid_q, sat_out_q, err_out_q;
  logic [CNT_W-1:0] cnt_out_q;

  // Stage-3 combinational helpers
  logic        first;
  logic [31:0] acc_base;
  logic [32:0] sum33;
  logic        sat_now;
  logic        close;

  // Stage 1: register raw inputs; last is meaningless without valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_sample_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
    end else begin
      s1_sample_q <= sample_in;
      s1_valid_q  <= sample_valid;
      s1_last_q   <= sample_valid & sample_last;
    end
  end

  // Square is never negative, so zero/sign extension to 32 bits is equivalent
  always_comb begin
    sq_full = s1_sample_q * s1_sample_q;
    s2_sq_d = 32'(sq_full);
  end

  // Stage 2: register the square alongside its control bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_sq_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_sq_q    <= s2_sq_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
    end
  end

  // Stage 3 next-state: saturating add, counter and close decision
  always_comb begin
    first    = (state_q == StIdle);
    // The opening sample restarts from zero, so no clear cycle is needed
    acc_base = first ? 32'd0 : acc_q;
    sum33    = {1'b0, acc_base} + {1'b0, s2_sq_q};
    sat_now  = sum33[32] || (acc_base == 32'hFFFF_FFFF);
    acc_d    = sat_now ? 32'hFFFF_FFFF : sum33[31:0];
    sat_d    = (first ? 1'b0 : sat_q) | sat_now;
    cnt_d    = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    close    = s2_last_q || (cnt_d == MaxCnt);
  end

  // Stage 3 frame FSM and accumulator; gaps hold all frame state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      close_q <= 1'b0;
    end else if (s2_valid_q) begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      err_q   <= close && !s2_last_q;
      close_q <= close;
      state_q <= close ? StIdle : StAccum;
    end else begin
      close_q <= 1'b0;
    end
  end

  // Result stage: capture the closed frame one clock after it closes; a new
  // frame may overwrite the accumulator on this same edge without harm
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      sat_out_q <= 1'b0;
      err_out_q <= 1'b0;
      cnt_out_q <= '0;
    end else begin
      valid_q <= close_q;
      if (close_q) begin
        data_q    <= acc_q;
        sat_out_q <= sat_q;
        err_out_q <= err_q;
        cnt_out_q <= cnt_q;
      end
    end
  end

  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign sat_flag     = sat_out_q;
  assign frame_err    = err_out_q;
  assign sample_count = cnt_out_q;

endmodule

// File: tb/tb_sumsq_accum.sv
// Self-checking bench for sumsq_accum: directed scenarios plus a random stream
// scored against a plain-arithmetic frame model.
module tb_sumsq_accum;

  localparam int SW = 16;
  localparam int ML = 4;
  localparam int CW = 11;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic signed [SW-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic                 sample_last = 1'b0;
  logic [31:0]          data_out;
  logic                 data_valid;
  logic                 sat_flag;
  logic                 frame_err;
  logic [CW-1:0]        sample_count;

  sumsq_accum #(.SAMPLE_W(SW), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_last  (sample_last),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .sat_flag     (sat_flag),
    .frame_err    (frame_err),
    .sample_count (sample_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]   d;
    logic          sat;
    logic          err;
    logic [CW-1:0] cnt;
    int            at;
  } res_t;

  res_t obs[$];
  res_t exp_q[$];
  int   edge_n = 0;
  int   n_chk = 0;
  int   n_err = 0;

  // Frame model state
  bit     m_open = 0;
  longint m_sum;
  int     m_cnt;
  bit     m_sat;

  // Record every emitted result with the edge index at which it appeared
  always @(posedge clock) begin
    res_t r;
    edge_n++;
    #1;
    if (data_valid === 1'b1) begin
      r.d = data_out; r.sat = sat_flag; r.err = frame_err; r.cnt = sample_count; r.at = edge_n;
      obs.push_back(r);
    end
  end

  // Drive one clock of input and advance the frame model on acceptance
  task automatic apply(input logic signed [SW-1:0] s, input bit v, input bit l);
    res_t e;
    sample_in = s; sample_valid = v; sample_last = l;
    @(posedge clock); #1;
    if (v) begin
      if (!m_open) begin
        m_open = 1; m_sum = 0; m_cnt = 0; m_sat = 0;
      end else if (m_sum >= 64'hFFFF_FFFF) begin
        m_sat = 1;
      end
      m_sum = m_sum + longint'(s) * longint'(s);
      if (m_sum > 64'hFFFF_FFFF) m_sat = 1;
      m_cnt++;
      if (l || m_cnt == ML) begin
        e.d = m_sat ? 32'hFFFF_FFFF : m_sum[31:0];
        e.sat = m_sat; e.err = !l; e.cnt = CW'(m_cnt); e.at = edge_n + 3;
        exp_q.push_back(e);
        m_open = 0;
      end
    end
  endtask

  task automatic drain();
    repeat (6) apply('0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_chk++; if (data_out !== 32'd0) begin n_err++; $display("FAIL reset_data got %h want 0", data_out); end
    n_chk++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", data_valid); end
    n_chk++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat got %b want 0", sat_flag); end
    n_chk++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", frame_err); end
    n_chk++; if (sample_count !== '0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", sample_count); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    res_t r, e;
    obs.delete(); exp_q.delete();
    apply(3, 1, 0); apply(-4, 1, 1); drain();
    n_chk++;
    if (obs.size() != 1) begin n_err++; $display("FAIL basic_pulses got %0d want 1", obs.size()); end
    else begin
      r = obs.pop_front(); e = exp_q.pop_front();
      n_chk++; if (r.d !== 32'd25) begin n_err++; $display("FAIL basic_data got %0d want 25", r.d); end
      n_chk++; if (r.cnt !== CW'(2)) begin n_err++; $display("FAIL basic_cnt got %0d want 2", r.cnt); end
      n_chk++; if (r.sat !== 1'b0 || r.err !== 1'b0) begin n_err++; $display("FAIL basic_flags got %b%b want 00", r.sat, r.err); end
      n_chk++; if (r.at != e.at) begin n_err++; $display("FAIL basic_latency got edge %0d want %0d", r.at, e.at); end
    end
    // Result must be held after the pulse
    n_chk++; if (data_out !== 32'd25) begin n_err++; $display("FAIL basic_hold got %0d want 25", data_out); end
  endtask

  task automatic test_saturation();
    res_t r;
    obs.delete(); exp_q.delete();
    repeat (3) apply(-32768, 1, 0);
    apply(-32768, 1, 1);
    apply(2, 1, 1);
    drain();
    n_chk++;
    if (obs.size() != 2) begin n_err++; $display("FAIL sat_pulses got %0d want 2", obs.size()); end
    else begin
      r = obs.pop_front();
      n_chk++; if (r.d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_data got %h want ffffffff", r.d); end
      n_chk++; if (r.sat !== 1'b1) begin n_err++; $display("FAIL sat_flag got %b want 1", r.sat); end
      n_chk++; if (r.cnt !== CW'(4) || r.err !== 1'b0) begin n_err++; $display("FAIL sat_cnt got %0d/%b want 4/0", r.cnt, r.err); end
      r = obs.pop_front();
      n_chk++; if (r.d !== 32'd4 || r.sat !== 1'b0) begin n_err++; $display("FAIL sat_next got %0d/%b want 4/0", r.d, r.sat); end
    end
  endtask

  task automatic test_back_to_back();
    res_t r0, r1, r2;
    obs.delete(); exp_q.delete();
    apply(1, 1, 0); apply(2, 1, 1); apply(5, 1, 1);
    apply(1, 1, 0); repeat (3) apply('0, 0, 0); apply(1, 1, 1);
    drain();
    n_chk++;
    if (obs.size() != 3) begin n_err++; $display("FAIL b2b_pulses got %0d want 3", obs.size()); end
    else begin
      r0 = obs.pop_front(); r1 = obs.pop_front(); r2 = obs.pop_front();
      n_chk++; if (r0.d !== 32'd5) begin n_err++; $display("FAIL b2b_a got %0d want 5", r0.d); end
      n_chk++; if (r1.d !== 32'd25) begin n_err++; $display("FAIL b2b_b got %0d want 25", r1.d); end
      n_chk++; if (r1.at != r0.at + 1) begin n_err++; $display("FAIL b2b_spacing got %0d want %0d", r1.at, r0.at + 1); end
      n_chk++; if (r2.d !== 32'd2 || r2.cnt !== CW'(2)) begin n_err++; $display("FAIL gap_frame got %0d/%0d want 2/2", r2.d, r2.cnt); end
    end
  endtask

  task automatic test_forced_close();
    res_t r;
    obs.delete(); exp_q.delete();
    repeat (5) apply(1, 1, 0);
    apply(1, 1, 1);
    drain();
    n_chk++;
    if (obs.size() != 2) begin n_err++; $display("FAIL force_pulses got %0d want 2", obs.size()); end
    else begin
      r = obs.pop_front();
      n_chk++; if (r.d !== 32'd4 || r.cnt !== CW'(4) || r.err !== 1'b1) begin n_err++; $display("FAIL force_first got %0d/%0d/%b want 4/4/1", r.d, r.cnt, r.err); end
      r = obs.pop_front();
      n_chk++; if (r.d !== 32'd2 || r.cnt !== CW'(2) || r.err !== 1'b0) begin n_err++; $display("FAIL force_second got %0d/%0d/%b want 2/2/0", r.d, r.cnt, r.err); end
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    obs.delete(); exp_q.delete();
    apply(10, 1, 0); apply(10, 1, 0);
    #2 reset = 1'b0;
    sample_valid = 1'b0; sample_last = 1'b0;
    m_open = 0;
    #1;
    n_chk++; if (data_out !== 32'd0 || sample_count !== '0) begin n_err++; $display("FAIL rstmid_data got %0d/%0d want 0/0", data_out, sample_count); end
    n_chk++; if (data_valid !== 1'b0 || sat_flag !== 1'b0 || frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got %b%b%b want 000", data_valid, sat_flag, frame_err); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    drain();
    n_chk++; if (obs.size() != 0) begin n_err++; $display("FAIL rstmid_nopulse got %0d pulses want 0", obs.size()); end
    obs.delete();
    apply(7, 1, 1); drain();
    n_chk++;
    if (obs.size() != 1) begin n_err++; $display("FAIL rstmid_after got %0d pulses want 1", obs.size()); end
    else begin
      r = obs.pop_front();
      n_chk++; if (r.d !== 32'd49 || r.cnt !== CW'(1)) begin n_err++; $display("FAIL rstmid_after got %0d/%0d want 49/1", r.d, r.cnt); end
    end
  endtask

  task automatic test_random();
    res_t r, e;
    logic signed [SW-1:0] s;
    bit v, l;
    obs.delete(); exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 8);
      l = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0, 1: s = -32768;
        2: s = 32767;
        default: s = SW'($urandom);
      endcase
      apply(s, v, l);
    end
    drain();
    n_chk++; if (obs.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", obs.size(), exp_q.size()); end
    while (obs.size() > 0 && exp_q.size() > 0) begin
      r = obs.pop_front(); e = exp_q.pop_front();
      n_chk++; if (r.d !== e.d) begin n_err++; $display("FAIL rand_data got %h want %h", r.d, e.d); end
      n_chk++; if (r.cnt !== e.cnt) begin n_err++; $display("FAIL rand_cnt got %0d want %0d", r.cnt, e.cnt); end
      n_chk++; if (r.sat !== e.sat || r.err !== e.err) begin n_err++; $display("FAIL rand_flags got %b%b want %b%b", r.sat, r.err, e.sat, e.err); end
      n_chk++; if (r.at != e.at) begin n_err++; $display("FAIL rand_latency got edge %0d want %0d", r.at, e.at); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_forced_close();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
